// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer and hazard controller for a 5-stage MIPS pipeline.
// Produces the latch enables, the IF/ID flush and the ID/EX bubble. It also
// drains the pipeline after a HALT opcode and counts the advancing cycles.
module pipeline_sequencer #(
  parameter int                   NB_OPCODE    = 6,
  parameter int                   NB_REG_ADDR  = 5,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 6'b111111,
  parameter int                   DRAIN_CYCLES = 4,
  parameter int                   NB_CYCLE_CNT = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_mode_step,
  input  logic                    i_step,
  input  logic [NB_OPCODE-1:0]    i_id_opcode,
  input  logic [NB_REG_ADDR-1:0]  i_id_rs,
  input  logic [NB_REG_ADDR-1:0]  i_id_rt,
  input  logic                    i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0]  i_ex_rt,
  input  logic                    i_branch_taken,
  input  logic                    i_jump,
  output logic                    o_pipe_en,
  output logic                    o_pc_en,
  output logic                    o_if_id_en,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_bubble,
  output logic                    o_running,
  output logic                    o_halted,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  // The counter only has to hold DRAIN_CYCLES-1.
  localparam int NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  logic [2:0]              state_q, state_d;
  logic                    step_mode_q, step_mode_d;
  logic [NB_DRAIN-1:0]     drain_cnt_q, drain_cnt_d;
  logic [NB_CYCLE_CNT-1:0] cycle_cnt_q, cycle_cnt_d;

  logic adv, lu, is_halt, in_exec;

  // Advance and hazard qualifiers shared by the output and next-state logic.
  always_comb begin
    in_exec = (state_q == ST_RUN) || (state_q == ST_STEP);
    adv     = (state_q == ST_RUN) ||
              ((state_q == ST_STEP) && i_step) ||
              ((state_q == ST_DRAIN) && (!step_mode_q || i_step));
    lu      = i_ex_mem_read && (i_ex_rt != '0) &&
              ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    is_halt = (i_id_opcode == HALT_OPCODE);
  end

  // Pipeline control outputs. A load-use stall holds PC and IF/ID and takes
  // priority over any redirect or HALT that is sitting in ID.
  always_comb begin
    o_pipe_en      = adv;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    if (adv) begin
      if (state_q == ST_DRAIN) begin
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end else if (lu) begin
        o_id_ex_bubble = 1'b1;
      end else if (is_halt) begin
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end else begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = i_branch_taken || i_jump;
      end
    end
    o_running     = in_exec || (state_q == ST_DRAIN);
    o_halted      = (state_q == ST_HALTED);
    o_cycle_count = cycle_cnt_q;
  end

  // Next state: start, HALT detection, drain countdown and the cycle counter.
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q + {{(NB_CYCLE_CNT-1){1'b0}}, adv};
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          step_mode_d = i_mode_step;
          state_d     = i_mode_step ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (adv && !lu && is_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (drain_cnt_q == '0) state_d = ST_HALTED;
          else                   drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

endmodule
